// File: rtl/seq_mult32_pkg.sv
// seq_mult32_pkg: shared state encoding and sizing for the sequential multiplier
package seq_mult32_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int WIDTH = 32;
    localparam int STEPS = 32;
endpackage

// File: rtl/seq_mult32_if.sv
// seq_mult32_if: operand/product valid-ready bus of the sequential multiplier
interface seq_mult32_if;
    import seq_mult32_pkg::*;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, product, busy);
    modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, product, busy);
endinterface

// File: rtl/seq_mult32_bcla32.sv
// bcla32: 32-bit adder built from eight 4-bit carry-lookahead blocks
module bcla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] p;
    logic [31:0] g;
    logic [32:0] c;
    assign p    = a ^ b;
    assign g    = a & b;
    assign c[0] = cin;
    genvar i;
    for (i = 0; i < 8; i++) begin : g_blk
        localparam int K = 4 * i;
        assign c[K+1] = g[K] | (p[K] & c[K]);
        assign c[K+2] = g[K+1] | (p[K+1] & g[K]) | (p[K+1] & p[K] & c[K]);
        assign c[K+3] = g[K+2] | (p[K+2] & g[K+1]) | (p[K+2] & p[K+1] & g[K])
                      | (p[K+2] & p[K+1] & p[K] & c[K]);
        assign c[K+4] = g[K+3] | (p[K+3] & g[K+2]) | (p[K+3] & p[K+2] & g[K+1])
                      | (p[K+3] & p[K+2] & p[K+1] & g[K])
                      | (p[K+3] & p[K+2] & p[K+1] & p[K] & c[K]);
    end
    assign sum  = p ^ c[31:0];
    assign cout = c[32];
endmodule

// File: rtl/seq_mult32.sv
// seq_mult32: unsigned 32x32->64 shift-and-add multiplier, one bcla32 add per cycle
module seq_mult32
    import seq_mult32_pkg::*;
#(
    parameter bit ZERO_SKIP = 1'b0
) (
    input logic         clk,
    input logic         rst_n,
    seq_mult32_if.slave bus
);
    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [5:0]       cnt;
    logic             accept;
    logic             zero;

    assign accept = bus.in_valid && state == IDLE;
    assign zero   = ZERO_SKIP && (bus.a == '0 || bus.b == '0);
    assign addend = acc_lo[0] ? mcand : '0;

    bcla32 u_add (
        .a   (acc_hi),
        .b   (addend),
        .cin (1'b0),
        .sum (sum),
        .cout(cout)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = IDLE;
        state_nxt = state == IDLE ? (accept ? (zero ? DONE : RUN) : IDLE)
                  : state == RUN  ? (cnt == 6'(STEPS - 1) ? DONE : RUN)
                  : state == DONE ? (bus.out_ready ? IDLE : DONE)
                  : IDLE;
    end

    // Skipped operations clear the accumulator so DONE presents zero.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
        end else if (accept) begin
            mcand  <= bus.a;
            acc_hi <= '0;
            acc_lo <= zero ? '0 : bus.b;
            cnt    <= '0;
        end else if (state == RUN) begin
            {acc_hi, acc_lo} <= {cout, sum, acc_lo[WIDTH-1:1]};
            cnt              <= cnt + 6'd1;
        end

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.busy      = state != IDLE;
    assign bus.product   = state == DONE ? {acc_hi, acc_lo} : '0;
endmodule

// File: tb/tb_seq_mult32.sv
// tb_seq_mult32: directed and random product checks against an arithmetic model
module tb_seq_mult32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors = 0;
    int   lat;

    always #5 clk = ~clk;

    seq_mult32_if bus ();
    seq_mult32_if bus_zs ();

    seq_mult32 #(.ZERO_SKIP(1'b0)) dut    (.clk(clk), .rst_n(rst_n), .bus(bus));
    seq_mult32 #(.ZERO_SKIP(1'b1)) dut_zs (.clk(clk), .rst_n(rst_n), .bus(bus_zs));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done();
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic mult(input logic [31:0] x, input logic [31:0] y, input int hold);
        logic [63:0] exp;
        exp = {32'd0, x} * {32'd0, y};
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);
        bus.a = x;
        bus.b = y;
        bus.in_valid = 1'b1;
        bus.out_ready = (hold == 0);
        step();
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        check("run_flags", 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'(3'b001));
        wait_done();
        check("latency", 64'(lat), 64'd33);
        for (int i = 0; i < hold; i++) begin
            check("hold_product", bus.product, exp);
            check("hold_flags", 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'(3'b101));
            step();
        end
        bus.out_ready = 1'b1;
        check("product", bus.product, exp);
        step();
        check("post_handshake", 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'(3'b010));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b1;
        bus_zs.in_valid = 1'b0;
        bus_zs.a = '0;
        bus_zs.b = '0;
        bus_zs.out_ready = 1'b1;
        @(negedge clk);
        check("reset_flags", 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'(3'b010));
        check("reset_product", bus.product, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        mult(32'd3, 32'd5, 0);
        mult(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        mult(32'h12345678, 32'h9ABCDEF0, 10);
        check("known_product", 64'h0B00EA4E242D2080, {32'd0, 32'h12345678} * {32'd0, 32'h9ABCDEF0});

        bus.a = 32'd7;
        bus.b = 32'd9;
        bus.in_valid = 1'b1;
        step();
        bus.a = 32'h80000000;
        bus.b = 32'd2;
        wait_done();
        check("b2b_lat1", 64'(lat), 64'd33);
        check("b2b_prod1", bus.product, 64'd63);
        check("b2b_done_flags", 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'(3'b101));
        step();
        check("b2b_gap_flags", 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'(3'b010));
        step();
        bus.in_valid = 1'b0;
        check("b2b_accept2", 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'(3'b001));
        wait_done();
        check("b2b_lat2", 64'(lat), 64'd33);
        check("b2b_prod2", bus.product, 64'h0000000100000000);
        step();

        bus.a = 32'h0000FFFF;
        bus.b = 32'h0000FFFF;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_flags", 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'(3'b010));
        check("async_reset_product", bus.product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        check("no_stale_valid", 64'({bus.out_valid, bus.busy}), 64'd0);
        mult(32'd6, 32'd7, 0);

        bus_zs.a = 32'd0;
        bus_zs.b = 32'hDEADBEEF;
        bus_zs.in_valid = 1'b1;
        step();
        bus_zs.in_valid = 1'b0;
        check("zs_fast_flags", 64'({bus_zs.out_valid, bus_zs.in_ready, bus_zs.busy}), 64'(3'b101));
        check("zs_product", bus_zs.product, 64'd0);
        step();
        check("zs_post_flags", 64'({bus_zs.out_valid, bus_zs.in_ready, bus_zs.busy}), 64'(3'b010));
        mult(32'd0, 32'hDEADBEEF, 0);

        for (int i = 0; i < 16; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            x = $urandom;
            y = (i % 5 == 4) ? 32'd0 : $urandom;
            mult(x, y, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
